// File: rtl/gray_codec_pkg.sv
// gray_codec_pkg: shared mode encodings and counter width for the Gray/binary codec pipe
package gray_codec_pkg;
    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;
    localparam int CNT_W = 16;
endpackage

// File: rtl/gray_codec_stage.sv
// gray_codec_stage: one pipeline stage converting its chunk of every lane and forwarding running parity
module gray_codec_stage
    import gray_codec_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int IDX    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ready,
    input  logic                   prev_valid,
    input  logic                   prev_mode,
    input  logic [LANES*WIDTH-1:0] prev_word,
    input  logic [LANES*WIDTH-1:0] prev_part,
    input  logic [LANES-1:0]       prev_par,
    output logic                   valid,
    output logic                   mode,
    output logic [LANES*WIDTH-1:0] word,
    output logic [LANES*WIDTH-1:0] part,
    output logic [LANES-1:0]       par
);
    localparam int C  = WIDTH / STAGES;
    localparam int LO = WIDTH - (IDX + 1) * C;
    localparam int HI = LO + C - 1;

    logic                   valid_q, valid_d, mode_q, mode_d, load;
    logic [LANES*WIDTH-1:0] word_q, word_d, part_q, part_d, part_c;
    logic [LANES-1:0]       par_q, par_d, par_c;
    logic [WIDTH-1:0]       wl, bg;
    logic                   p;

    assign load = prev_valid && ready;

    // convert this stage's chunk of each lane; Gray->binary continues the parity from the stages above
    always_comb begin
        part_c = prev_part;
        par_c = prev_par;
        wl = '0;
        bg = '0;
        p = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            wl = prev_word[k*WIDTH +: WIDTH];
            bg = wl ^ (wl >> 1);
            p = prev_par[k];
            for (int i = HI; i >= LO; i--) begin
                p = p ^ wl[i];
                part_c[k*WIDTH+i] = (prev_mode == MODE_G2B) ? p : bg[i];
            end
            par_c[k] = p;
        end
    end

    // load when upstream offers and we can take it; drop valid once handed off with nothing new
    always_comb begin
        valid_d = ready ? prev_valid : valid_q;
        mode_d = load ? prev_mode : mode_q;
        word_d = load ? prev_word : word_q;
        part_d = load ? part_c : part_q;
        par_d = load ? par_c : par_q;
    end

    // stage register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q <= 1'b0;
            word_q <= '0;
            part_q <= '0;
            par_q <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q <= mode_d;
            word_q <= word_d;
            part_q <= part_d;
            par_q <= par_d;
        end
    end

    assign valid = valid_q;
    assign mode = mode_q;
    assign word = word_q;
    assign part = part_q;
    assign par = par_q;
endmodule

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: pipelined multi-lane Gray/binary converter with valid/ready flow control
module gray_codec_pipe
    import gray_codec_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_mode,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       xfer_cnt
);
    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_cfg
        $fatal(1, "gray_codec_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic [STAGES:0]                  v, m;
    logic [STAGES:0][LANES*WIDTH-1:0] w, pt;
    logic [STAGES:0][LANES-1:0]       pr;
    logic [STAGES:1]                  rdy;
    logic                             r;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             unused_tail;

    assign v[0] = in_valid;
    assign m[0] = in_mode;
    assign w[0] = in_data;
    assign pt[0] = '0;
    assign pr[0] = '0;

    // ready ripples back from the output: a stage can take a word if empty or its successor can
    always_comb begin
        rdy = '0;
        r = out_ready;
        for (int s = STAGES; s >= 1; s--) begin
            r = !v[s] || r;
            rdy[s] = r;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        gray_codec_stage #(
            .WIDTH (WIDTH),
            .LANES (LANES),
            .STAGES(STAGES),
            .IDX   (s)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .ready     (rdy[s+1]),
            .prev_valid(v[s]),
            .prev_mode (m[s]),
            .prev_word (w[s]),
            .prev_part (pt[s]),
            .prev_par  (pr[s]),
            .valid     (v[s+1]),
            .mode      (m[s+1]),
            .word      (w[s+1]),
            .part      (pt[s+1]),
            .par       (pr[s+1])
        );
    end

    assign in_ready = rdy[1];
    assign out_valid = v[STAGES];
    assign out_mode = m[STAGES];
    assign out_data = pt[STAGES];
    assign unused_tail = ^{w[STAGES], pr[STAGES]};

    // count completed output handshakes, wrapping naturally
    always_comb begin
        cnt_d = cnt_q + CNT_W'(out_valid && out_ready);
    end

    // transfer counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe: directed self-checking bench for gray_codec_pipe (WIDTH=8, LANES=2, STAGES=2)
module tb_gray_codec_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [15:0] in_data, out_data, xfer_cnt;
    int          checks = 0, errors = 0;
    int          idx, acc_n, sent, got, cyc;
    logic        acc;
    logic [15:0] held, e;
    logic [15:0] q[$];
    logic        qm[$];
    logic [15:0] mix_d[3] = '{16'h00FF, 16'h00AA, 16'h0080};
    logic        mix_m[3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] mix_e[3] = '{16'h00AA, 16'h00FF, 16'h00FF};
    logic [15:0] bp_d[3] = '{16'h1234, 16'h1234, 16'h5555};
    logic        bp_m[3] = '{1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    gray_codec_pipe #(.WIDTH(8), .LANES(2), .STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mode (out_mode),
        .out_data (out_data),
        .xfer_cnt (xfer_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_g2b(input logic [7:0] g);
        logic [7:0] b = g;
        for (int sh = 1; sh < 8; sh++) b = b ^ (g >> sh);
        return b;
    endfunction

    function automatic logic [7:0] ref_b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [15:0] ref_conv(input logic md, input logic [15:0] d);
        return md ? {ref_b2g(d[15:8]), ref_b2g(d[7:0])} : {ref_g2b(d[15:8]), ref_g2b(d[7:0])};
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        in_valid = 1'b1; in_mode = 1'b0; in_data = 16'h80FF;
        step();
        in_valid = 1'b0;
        chk("g2b_latency_1", out_valid, 0);
        step();
        chk("g2b_valid", out_valid, 1);
        chk("g2b_data", out_data, 16'hFFAA);
        chk("g2b_mode", out_mode, 0);
        step();
        chk("g2b_xfer_cnt", xfer_cnt, 1);
        chk("g2b_drained", out_valid, 0);

        in_valid = 1'b1; in_mode = 1'b1; in_data = 16'h05AA;
        step();
        in_valid = 1'b0;
        step();
        chk("b2g_valid", out_valid, 1);
        chk("b2g_data", out_data, 16'h07FF);
        chk("b2g_mode", out_mode, 1);
        step();

        for (int t = 0; t < 4; t++) begin
            in_valid = t < 3;
            if (t < 3) begin
                in_mode = mix_m[t];
                in_data = mix_d[t];
            end
            step();
            if (t >= 1) begin
                chk("mix_valid", out_valid, 1);
                chk("mix_data", out_data, mix_e[t-1]);
                chk("mix_mode", out_mode, mix_m[t-1]);
            end
        end
        in_valid = 1'b0;
        step();
        chk("mix_xfer_cnt", xfer_cnt, 5);

        out_ready = 1'b0;
        idx = 0;
        for (int t = 0; t < 5; t++) begin
            in_valid = 1'b1;
            in_mode = bp_m[idx];
            in_data = bp_d[idx];
            acc = in_ready;
            step();
            if (acc && idx < 2) idx++;
            else if (acc) idx = 3;
        end
        in_valid = 1'b0;
        acc_n = idx;
        chk("bp_accepted", acc_n, 2);
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_first_data", out_data, 16'h1C27);
        chk("bp_first_mode", out_mode, 0);
        held = out_data;
        step();
        step();
        chk("bp_stall_stable", out_data, held);
        chk("bp_stall_mode", out_mode, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", in_ready, 1);
        step();
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_data", out_data, 16'h1B2E);
        chk("bp_second_mode", out_mode, 1);
        step();
        chk("bp_drained", out_valid, 0);
        chk("bp_xfer_cnt", xfer_cnt, 7);

        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 16'hDEAD;
        step();
        in_mode = 1'b1; in_data = 16'hBEEF;
        step();
        in_valid = 1'b0;
        chk("mid_inflight", out_valid, 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_xfer", xfer_cnt, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            chk("mid_no_ghost", out_valid, 0);
        end

        sent = 0; got = 0; cyc = 0;
        while (got < 65536 && cyc < 70000) begin
            if (sent < 65536) begin
                in_valid = 1'b1;
                in_mode = sent[8];
                in_data = {~sent[7:0], sent[7:0]};
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(ref_conv(in_mode, in_data));
                qm.push_back(in_mode);
            end
            step();
            cyc++;
            if (acc) sent++;
            if (out_valid) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    acc = qm.pop_front();
                    if (got < 1024) begin
                        chk("sweep_data", out_data, e);
                        chk("sweep_mode", out_mode, acc);
                    end
                end else begin
                    chk("sweep_unexpected_out", 1, 0);
                end
                got++;
            end
        end
        chk("sweep_all_out", got, 65536);
        chk("wrap_pre_cnt", xfer_cnt, 16'hFFFF);
        in_valid = 1'b0;
        step();
        chk("wrap_cnt_zero", xfer_cnt, 0);
        chk("wrap_drained", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
